// File: rtl/cla_word_serial_adder.sv
// Word-serial wide adder/subtractor: one 10-bit carry-lookahead slice processes
// the operands LSW first, with the slice carry-out registered between words.
module cla_word_serial_adder #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic                  cin,
  input  logic [10*WORDS-1:0]   a_in,
  input  logic [10*WORDS-1:0]   b_in,
  output logic                  busy,
  output logic                  done,
  output logic [10*WORDS-1:0]   sum_out,
  output logic                  cout_out,
  output logic                  overflow,
  output logic [1:0]            state_o
);
  // Handshake: start is a request sampled only in IDLE or DONE (ignored in RUN);
  // done is a one-cycle valid pulse for sum_out/cout_out/overflow, no backpressure.

  localparam int W  = 10 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    sum_out_q, sum_out_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [IW-1:0]   idx_q, idx_d;

  int              base;
  logic [10:0]     slice;

  // Flattened lookahead: every carry is a two-level function of g/p and c0.
  function automatic logic [10:0] cla10(input logic [9:0] x, input logic [9:0] y,
                                        input logic c0);
    logic [9:0]  g;
    logic [9:0]  p;
    logic [10:0] c;
    logic        term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < 10; i++) begin
      term = c0;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[10], p ^ c[9:0]};
  endfunction

  assign base  = 10 * int'(idx_q);
  assign slice = cla10(a_q[base +: 10], b_q[base +: 10], carry_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sum_out_q <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      sum_out_q <= sum_out_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sum_out_d = sum_out_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    idx_d     = idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = op_sub ? ~b_in : b_in;
          carry_d = op_sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d             = slice[10];
        res_d[base +: 10]   = slice[9:0];
        if (idx_q == LAST) begin
          state_d   = DONE;
          sum_out_d = res_d;
          cout_d    = slice[10];
          // b_q already holds the inverted operand in subtract mode.
          ovf_d     = (a_q[W-1] ^ slice[9]) & (b_q[W-1] ^ slice[9]);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum_out  = sum_out_q;
  assign cout_out = cout_q;
  assign overflow = ovf_q;
  assign state_o  = state_q;
endmodule

// File: tb/tb_cla_word_serial_adder.sv
// Directed bench for the word-serial adder: arithmetic reference model checked
// every cycle, plus literal expectations from hand-worked vectors.
module tb_cla_word_serial_adder;
  localparam int WORDS = 4;
  localparam int W     = 10 * WORDS;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, cout_out, overflow;
  logic [W-1:0] sum_out;
  logic [1:0]   state_o;

  always #5 clk = ~clk;

  cla_word_serial_adder #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .cin(cin),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .sum_out(sum_out),
    .cout_out(cout_out), .overflow(overflow), .state_o(state_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum = '0, p_sum = '0;
  logic         m_cout = 1'b0, p_cout = 1'b0;
  logic         m_ovf = 1'b0, p_ovf = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic model_compute(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, input logic ci);
    longint sa, sb, r;
    logic [W:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r      = sa - sb;
      p_sum  = a - b;
      p_cout = (a >= b);
    end else begin
      r      = sa + sb + longint'(ci);
      u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      p_sum  = u[W-1:0];
      p_cout = u[W];
    end
    p_ovf = (r > ((64'sd1 <<< (W-1)) - 1)) || (r < -(64'sd1 <<< (W-1)));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_done) begin
        m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
        exp_q.push_back(p_sum);
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        model_compute(a_in, b_in, op_sub, cin);
        m_left = WORDS;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_left > 0));
    check("done", 64'(done), 64'(m_done));
    check("sum_out", 64'(sum_out), 64'(m_sum));
    check("cout_out", 64'(cout_out), 64'(m_cout));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (done && exp_q.size() > 0) check("done_sum_q", 64'(sum_out), 64'(exp_q.pop_front()));
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic ci);
    a_in = a; b_in = b; op_sub = sub; cin = ci; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic ci, input logic [W-1:0] es,
                         input logic ec, input logic eo);
    int lat;
    do_start(a, b, sub, ci);
    wait_done(lat);
    check({name, "_lat"}, 64'(lat), 64'(WORDS));
    check({name, "_sum"}, 64'(sum_out), 64'(es));
    check({name, "_cout"}, 64'(cout_out), 64'(ec));
    check({name, "_ovf"}, 64'(overflow), 64'(eo));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int done_seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum_out), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_vec("add_carry", 40'h00000003FF, 40'h0000000001, 1'b0, 1'b0, 40'h0000000400, 1'b0, 1'b0);
    run_vec("ripple_cin", 40'hFFFFFFFFFF, 40'h0000000000, 1'b0, 1'b1, 40'h0000000000, 1'b1, 1'b0);
    run_vec("sub_borrow", 40'h0000000005, 40'h0000000007, 1'b1, 1'b0, 40'hFFFFFFFFFE, 1'b0, 1'b0);
    run_vec("sub_ok", 40'h0000000007, 40'h0000000005, 1'b1, 1'b1, 40'h0000000002, 1'b1, 1'b0);
    run_vec("add_ovf", 40'h7FFFFFFFFF, 40'h0000000001, 1'b0, 1'b0, 40'h8000000000, 1'b0, 1'b1);
    run_vec("sub_ovf", 40'h8000000000, 40'h0000000001, 1'b1, 1'b0, 40'h7FFFFFFFFF, 1'b1, 1'b1);
    run_vec("mix_words", 40'h123456789A, 40'h0FEDCBA987, 1'b0, 1'b1, 40'h2222222222, 1'b0, 1'b0);

    // start during RUN is ignored
    do_start(40'h0000000010, 40'h0000000020, 1'b0, 1'b0);
    @(posedge clk); #1;
    a_in = 40'hAAAAAAAAAA; b_in = 40'h5555555555; op_sub = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat);
    check("ignore_lat", 64'(lat), 64'd2);
    check("ignore_sum", 64'(sum_out), 64'h30);

    // back-to-back from DONE
    do_start(40'h1, 40'h2, 1'b0, 1'b0);
    wait_done(lat);
    check("b2b_first_sum", 64'(sum_out), 64'h3);
    run_vec("b2b", 40'h0000000001, 40'h0000000002, 1'b0, 1'b0, 40'h0000000003, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("b2b_done_drop", 64'(done), 64'd0);

    // asynchronous reset mid-RUN at idx 2
    do_start(40'h00000003FF, 40'h0000000001, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_sum", 64'(sum_out), 64'd0);
    check("arst_cout", 64'(cout_out), 64'd0);
    check("arst_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("arst_no_done", 64'(done_seen), 64'd0);
    run_vec("after_rst", 40'h0000000064, 40'h00000000C8, 1'b0, 1'b0, 40'h000000012C, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
